// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, programmable wait states,
// word-organised storage with byte/half/word access and misalignment errors.
module dmem_responder #(
  parameter int unsigned AddressWidth = 10,
  parameter int unsigned WaitStates   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [AddressWidth-1:0] req_addr_i,
  input  logic [31:0]             req_wdata_i,
  input  logic [2:0]              req_funct3_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o
);
  localparam int unsigned IdxW  = AddressWidth - 2;
  localparam int unsigned Words = 1 << IdxW;
  localparam int unsigned CntW  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  r_state;
  logic [CntW-1:0]         r_cnt;
  logic                    r_we;
  logic [AddressWidth-1:0] r_addr;
  logic [31:0]             r_wdata;
  logic [2:0]              r_funct3;
  logic                    r_req_ready;
  logic                    r_rsp_valid;
  logic [31:0]             r_rdata;
  logic                    r_err;
  logic [31:0]             r_mem [Words];

  logic                    w_accept;
  logic                    w_commit;
  logic                    w_we;
  logic [AddressWidth-1:0] w_addr;
  logic [31:0]             w_wdata;
  logic [2:0]              w_funct3;
  logic [IdxW-1:0]         w_idx;
  logic [31:0]             w_word;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [31:0]             w_load;
  logic [31:0]             w_new_word;
  logic                    w_err;
  logic                    w_mem_we;

  assign w_accept = req_valid_i && r_req_ready;
  assign w_commit = ((r_state == IDLE) && w_accept && (WaitStates == 0)) ||
                    ((r_state == WAIT) && (r_cnt == '0));

  // With zero wait states the commit happens on the accept edge, so use the live request.
  assign w_we     = (r_state == IDLE) ? req_we_i     : r_we;
  assign w_addr   = (r_state == IDLE) ? req_addr_i   : r_addr;
  assign w_wdata  = (r_state == IDLE) ? req_wdata_i  : r_wdata;
  assign w_funct3 = (r_state == IDLE) ? req_funct3_i : r_funct3;

  assign w_idx  = w_addr[AddressWidth-1:2];
  assign w_word = r_mem[w_idx];
  assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (w_addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  // Access decode: error detection, load extension and store merge.
  always_comb begin
    w_err      = 1'b0;
    w_load     = 32'h0;
    w_new_word = w_word;
    case (w_funct3)
      3'd0: begin
        if (w_we) begin
          case (w_addr[1:0])
            2'd0:    w_new_word[7:0]   = w_wdata[7:0];
            2'd1:    w_new_word[15:8]  = w_wdata[7:0];
            2'd2:    w_new_word[23:16] = w_wdata[7:0];
            default: w_new_word[31:24] = w_wdata[7:0];
          endcase
        end else begin
          w_load = {{24{w_byte[7]}}, w_byte};
        end
      end
      3'd1: begin
        if (w_addr[0]) begin
          w_err = 1'b1;
        end else if (w_we) begin
          if (w_addr[1]) w_new_word[31:16] = w_wdata[15:0];
          else           w_new_word[15:0]  = w_wdata[15:0];
        end else begin
          w_load = {{16{w_half[15]}}, w_half};
        end
      end
      3'd2: begin
        if (w_addr[1:0] != 2'd0) w_err = 1'b1;
        else if (w_we)           w_new_word = w_wdata;
        else                     w_load = w_word;
      end
      3'd4: begin
        if (w_we) w_err = 1'b1;
        else      w_load = {24'h0, w_byte};
      end
      3'd5: begin
        if (w_we || w_addr[0]) w_err = 1'b1;
        else                   w_load = {16'h0, w_half};
      end
      default: w_err = 1'b1;
    endcase
  end

  assign w_mem_we = w_commit && w_we && !w_err;

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[w_idx] <= w_new_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_funct3    <= 3'h0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      if (w_commit) begin
        r_rdata <= (w_err || w_we) ? 32'h0 : w_load;
        r_err   <= w_err;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= req_we_i;
            r_addr      <= req_addr_i;
            r_wdata     <= req_wdata_i;
            r_funct3    <= req_funct3_i;
            r_req_ready <= 1'b0;
            if (WaitStates == 0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CntW'(WaitStates - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 0 and 3 wait states.
module tb_dmem_responder;
  logic            clk;
  logic            rst_n;
  logic [2:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0][9:0] req_addr;
  logic [2:0][31:0] req_wdata, rsp_rdata;
  logic [2:0][2:0] req_funct3;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .AddressWidth(10),
      .WaitStates  (g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_we_i    (req_we[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .req_funct3_i(req_funct3[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .rsp_err_o   (rsp_err[g])
    );
  end

  // One full transaction; lat counts edges from the accept edge until rsp_valid is seen.
  task automatic txn(input int d, input logic we, input logic [9:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_funct3[d] = f3;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready[0]); end
    total++; if (rsp_valid[0] !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rsp_valid[0]); end
    total++; if (rsp_rdata[0] !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata[0]); end
    total++; if (rsp_err[0] !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", rsp_err[0]); end
  endtask

  task automatic test_word_rt();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 10'h010, 32'hDEADBEEF, 3'd2, rd, er, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", lat); end
    total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL sw_rsp got=%b/%h want=0/0", er, rd); end
    txn(0, 1'b0, 10'h010, 32'h0, 3'd2, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rt got=%h want=deadbeef", rd); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat;
    logic [2:0]  f3s [5]  = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [9:0]  as  [5]  = '{10'h010, 10'h013, 10'h013, 10'h012, 10'h012};
    logic [31:0] exp [5]  = '{32'h80223344, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8022, 32'h00008022};
    txn(0, 1'b1, 10'h010, 32'h11223344, 3'd2, rd, er, lat);
    txn(0, 1'b1, 10'h013, 32'hFFFFFF80, 3'd0, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL sb_err got=%b want=0", er); end
    for (int i = 0; i < 5; i++) begin
      txn(0, 1'b0, as[i], 32'h0, f3s[i], rd, er, lat);
      total++;
      if (rd !== exp[i] || er !== 1'b0) begin
        bad++; $display("FAIL subword_load%0d got=%h/%b want=%h/0", i, rd, er, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 10'h012, 32'h55555555, 3'd2, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL sw_misalign got=%b/%h want=1/0", er, rd); end
    txn(0, 1'b0, 10'h010, 32'h0, 3'd2, rd, er, lat);
    total++; if (rd !== 32'h80223344) begin bad++; $display("FAIL misalign_nowrite got=%h want=80223344", rd); end
    txn(0, 1'b0, 10'h011, 32'h0, 3'd1, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL lh_misalign got=%b/%h want=1/0", er, rd); end
    txn(0, 1'b0, 10'h010, 32'h0, 3'd3, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL ld_f3_3 got=%b/%h want=1/0", er, rd); end
    txn(0, 1'b1, 10'h010, 32'h0, 3'd4, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL st_f3_4 got=%b want=1", er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 10'h020, 32'hAAAA5555, 3'd2, rd, er, lat);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'h010; req_funct3[0] = 3'd2;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    lat = 0;
    while (!rsp_valid[0] && lat < 20) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 10'h020; req_wdata[0] = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h80223344 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        bad++; $display("FAIL hold%0d got v=%b d=%h e=%b r=%b want v=1 d=80223344 e=0 r=0",
                        i, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
      end
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      bad++; $display("FAIL release got v=%b r=%b want v=0 r=1", rsp_valid[0], req_ready[0]);
    end
    rsp_ready[0] = 1'b0;
    txn(0, 1'b0, 10'h020, 32'h0, 3'd2, rd, er, lat);
    total++; if (rd !== 32'hAAAA5555) begin bad++; $display("FAIL ignored_req got=%h want=aaaa5555", rd); end
  endtask

  task automatic test_wait_sweep();
    logic [31:0] rd; logic er; int lat; int nrsp;
    txn(1, 1'b1, 10'h010, 32'hCAFEF00D, 3'd2, rd, er, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL ws0_latency got=%0d want=1", lat); end
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 10'h010; req_funct3[1] = 3'd2;
    rsp_ready[1] = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) begin
        nrsp++;
        total++; if (rsp_rdata[1] !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_data got=%h want=cafef00d", rsp_rdata[1]); end
      end
    end
    @(negedge clk);
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
    total++; if (nrsp != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", nrsp); end
    txn(2, 1'b1, 10'h040, 32'h01020304, 3'd2, rd, er, lat);
    total++; if (lat != 4) begin bad++; $display("FAIL ws3_latency got=%0d want=4", lat); end
    txn(2, 1'b0, 10'h040, 32'h0, 3'd2, rd, er, lat);
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL ws3_lw got=%h want=01020304", rd); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 10'h040; req_wdata[2] = 32'hFFFFFFFF; req_funct3[2] = 3'd2;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    total++; if (req_ready[2] !== 1'b0) begin bad++; $display("FAIL in_wait got=%b want=0", req_ready[2]); end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
      bad++; $display("FAIL async_rst got v=%b r=%b want v=0 r=1", rsp_valid[2], req_ready[2]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(2, 1'b0, 10'h040, 32'h0, 3'd2, rd, er, lat);
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL aborted_sw got=%h want=01020304", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    test_reset();
    test_word_rt();
    test_subword();
    test_errors();
    test_backpressure();
    test_wait_sweep();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-mapped data-memory target for the core's load/store port; the responder end of the core's data-memory requests.
- Accepts one request at a time over a valid/ready handshake and decodes byte/half/word width and signedness from funct3.
- Adds a programmable number of wait states and returns read data or a write acknowledgement over a valid/ready response channel.
- Holds a word-organised storage array. Later multi-cycle core variants and the bus fabric attach here.

Parameters:
- AddressWidth, 10, byte-address width; storage is 2^(AddressWidth-2) 32-bit words.
- WaitStates, 1, extra cycles between request accept and response (0..15).

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  responder can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  AddressWidth  byte address
- req_wdata_i  input  32  store data, right-aligned
- req_funct3_i  input  3  RISC-V load/store funct3
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  requester accepts response
- rsp_rdata_o  output  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err_o  output  1  misaligned access or illegal funct3

Behaviour:
- Reset:
  - Clock is clk_i; reset is asynchronous, active-low (rst_ni).
  - On assertion: state=IDLE, wait counter=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, req_ready_o=1 (combinational from IDLE).
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready_o=1 only in IDLE. rsp_valid_o=1 only in RESP.
- IDLE: a request is accepted at the edge where req_valid_i&&req_ready_o. On accept, latch we/addr/wdata/funct3.
  - WaitStates=0: commit at the same edge and go to RESP.
  - WaitStates>0: go to WAIT with counter=WaitStates-1.
- WAIT: decrement the counter each edge. At the edge where counter==0, commit and go to RESP.
- Commit = perform the store or capture load data, and register rsp_rdata_o/rsp_err_o.
  - With accept at edge E, commit occurs at edge E+WaitStates.
- RESP: hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable until rsp_valid_o&&rsp_ready_i.
  - At that edge go to IDLE and clear rsp_valid_o.
  - rsp_rdata_o and rsp_err_o keep their values until the next commit.
- Throughput: at most one transaction per WaitStates+2 cycles. No request overlap or pipelining. req_valid_i is ignored outside IDLE.
- Word index = addr[AddressWidth-1:2]. Byte lane = addr[1:0].
- Loads:
  - funct3 0 LB: sign-extend the selected byte.
  - funct3 4 LBU: zero-extend the selected byte.
  - funct3 1 LH: sign-extend halfword addr[1]. funct3 5 LHU: zero-extend halfword addr[1].
  - funct3 2 LW: full word.
- Stores:
  - funct3 0 SB: write wdata[7:0] to the selected byte.
  - funct3 1 SH: write wdata[15:0] to halfword addr[1].
  - funct3 2 SW: write the full word.
  - Unselected bytes are unchanged.
- Errors, rsp_err_o=1:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load funct3 3/6/7.
  - Store funct3 3..7.
  - On error: no storage write, rsp_rdata_o=0, and the response handshake still completes normally.
- Store response: rsp_rdata_o=0, rsp_err_o=0.
- Reset mid-operation:
  - Reset in WAIT aborts the request; the store is not performed.
  - Reset in RESP drops the response; a store already committed remains.
- Address wrap: none. The index covers the full AddressWidth space exactly.

Test Plan:
- Reset then idle:
  - Hold rst_ni=0 for 3 cycles, release -> req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - Assert rst_ni asynchronously mid-cycle in WAIT -> rsp_valid_o=0 and state=IDLE without waiting for a clock edge.
- Word round trip, WaitStates=1:
  - SW addr 0x010 data 0xDEADBEEF accepted at edge E -> rsp_valid_o rises after E+1 with err=0.
  - Then LW 0x010 -> rsp_rdata_o=0xDEADBEEF.
- Sub-word stores and sign extension:
  - SB 0x013 data 0x80 onto word 0x11223344 -> LW 0x010 returns 0x80223344.
  - LB 0x013 -> 0xFFFFFF80. LBU 0x013 -> 0x00000080.
  - LH 0x012 -> 0xFFFF8022. LHU 0x012 -> 0x00008022.
- Misalignment and illegal funct3:
  - SW 0x012 -> err=1, rdata=0, and memory word unchanged on a later LW.
  - LH 0x011 -> err=1.
  - Load funct3 3 -> err=1.
- Response backpressure:
  - Hold rsp_ready_i=0 for 5 cycles after rsp_valid_o -> valid, rdata and err stay stable, req_ready_o=0, a new req_valid_i is ignored.
  - Release rsp_ready_i -> IDLE the next cycle.
- Wait-state sweep:
  - WaitStates=0 -> accept at E gives rsp_valid_o in the cycle after E, and back-to-back transactions take 2 cycles each.
  - WaitStates=3 -> rsp_valid_o appears after edge E+3.
  - Reset asserted in WAIT for a SW -> memory unchanged.
